// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache: combinational hit path and a
// word-at-a-time line refill from the memory controller.
module inst_cache #(
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] pc,
  output logic        icache_hit,
  output logic [31:0] icache_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;
  localparam int LINE_LSB = OFFSET_W + 2;
  localparam int TAG_W    = 32 - INDEX_W - LINE_LSB;

  typedef enum logic {IDLE, REFILL} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES*WORDS];
  logic [INDEX_W-1:0]  refill_index_q;
  logic [TAG_W-1:0]    refill_tag_q;
  logic [OFFSET_W-1:0] cnt_q;

  logic [OFFSET_W-1:0] pc_offset;
  logic [INDEX_W-1:0]  pc_index;
  logic [TAG_W-1:0]    pc_tag;
  logic                unused_pc;

  logic start_refill;
  logic word_wr;
  logic line_done;

  assign pc_offset = pc[LINE_LSB-1:2];
  assign pc_index  = pc[INDEX_W+LINE_LSB-1:LINE_LSB];
  assign pc_tag    = pc[31:INDEX_W+LINE_LSB];
  assign unused_pc = ^pc[1:0];

  // The line under refill had its valid bit dropped at miss time, so it reads as a miss.
  assign icache_hit  = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign icache_inst = icache_hit ? data_q[{pc_index, pc_offset}] : '0;

  always_comb begin
    state_d      = state_q;
    start_refill = 1'b0;
    word_wr      = 1'b0;
    line_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!icache_hit) begin
          start_refill = 1'b1;
          state_d      = REFILL;
        end
      end
      REFILL: begin
        if (mem_done) begin
          word_wr = 1'b1;
          if (cnt_q == '1) begin
            line_done = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      cnt_q    <= '0;
    end else if (rdy) begin
      if (start_refill) begin
        valid_q[pc_index] <= 1'b0;
        mem_addr          <= {pc[31:LINE_LSB], {LINE_LSB{1'b0}}};
        mem_req           <= 1'b1;
        cnt_q             <= '0;
      end else if (word_wr) begin
        if (line_done) begin
          valid_q[refill_index_q] <= 1'b1;
          mem_req                 <= 1'b0;
        end else begin
          cnt_q    <= cnt_q + 1'b1;
          mem_addr <= mem_addr + 32'd4;
        end
      end
    end
  end

  // Arrays and captured refill target carry no reset; only valid bits gate their use.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      if (start_refill) begin
        refill_index_q <= pc_index;
        refill_tag_q   <= pc_tag;
      end
      if (word_wr) begin
        data_q[{refill_index_q, cnt_q}] <= mem_data;
      end
      if (line_done) begin
        tag_q[refill_index_q] <= refill_tag_q;
      end
    end
  end

endmodule
